// File: rtl/burst_sram_slave.sv
// -----------------------------------------------------------------------------
// burst_sram_slave
//
// Responder end of the cache/arbiter-to-memory burst protocol. Sits below
// mem_arb in place of the behavioural memory model and serves single- and
// multi-beat bursts from an internal synchronous word array with a fixed
// read latency.
//
// Parameters
//   ADDR_WIDTH      byte address width
//   DATA_WIDTH      beat width; the byte address advances DATA_WIDTH/8 per beat
//   BURSTLEN_WIDTH  burst length field width; beats = burst_len + 1
//   DEPTH_LOG2      log2 of array depth in words
//   RD_LATENCY      cycles from read acceptance to first rd_valid (1..8)
//   MEM_FILE        init file name of the behavioural model. Kept so this
//                   block drops into the same parameter list; the array is
//                   not preloaded here and starts with undefined contents, so
//                   fill it over the write port or with the FPGA tool's
//                   memory-init flow.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   addr         byte address of first beat, sampled at command acceptance
//   burst_len    beats-1, sampled at command acceptance
//   rd           read command request
//   wr           write beat request, data_in valid while high
//   data_in      write data
//   waitrequest  high = command/beat not accepted this cycle
//   data_out     read data, qualified by rd_valid
//   rd_valid     one read beat on data_out this cycle
//
// Build option
//   BURST_SRAM_STALL_EN  when defined, an 8-bit LFSR (x^8+x^6+x^5+x^4+1,
//                        seed 8'hA5) forces waitrequest high in IDLE and
//                        WR_BURST whenever lfsr[1:0] == 2'b00, to exercise
//                        the host's waitrequest handling.
// -----------------------------------------------------------------------------
module burst_sram_slave #(
  parameter int    ADDR_WIDTH     = 32,
  parameter int    DATA_WIDTH     = 32,
  parameter int    BURSTLEN_WIDTH = 3,
  parameter int    DEPTH_LOG2     = 14,
  parameter int    RD_LATENCY     = 2,
  parameter string MEM_FILE       = ""
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [BURSTLEN_WIDTH-1:0] burst_len,
  input  logic                      rd,
  input  logic                      wr,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic                      waitrequest,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      rd_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_LAT   = 2'd1;
  localparam logic [1:0] RD_BURST = 2'd2;
  localparam logic [1:0] WR_BURST = 2'd3;

  // Last value of the latency counter before moving to RD_BURST.
  localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

  logic [1:0]                state;
  logic [BURSTLEN_WIDTH-1:0] beat_cnt;
  logic [BURSTLEN_WIDTH-1:0] len_q;
  logic [2:0]                lat_cnt;
  logic [DEPTH_LOG2-1:0]     base_idx;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic [DEPTH_LOG2-1:0]     addr_idx;
  logic [DEPTH_LOG2-1:0]     burst_idx;
  logic [DEPTH_LOG2-1:0]     wr_idx;
  logic                      fsm_busy;
  logic                      stall;
  logic                      wr_take;
  logic                      rd_take;

  // Only the word-index bits of addr are decoded; byte-lane and upper bits
  // are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[ADDR_WIDTH-1:DEPTH_LOG2+2], addr[1:0]};
  localparam bit unused_mem_file = (MEM_FILE != "");

  assign addr_idx  = addr[DEPTH_LOG2+1:2];
  // Index arithmetic is modulo the array depth, so bursts wrap past the top.
  assign burst_idx = base_idx + DEPTH_LOG2'(beat_cnt);
  // Beat 0 of a write is taken straight from addr in IDLE; later beats come
  // from the latched base plus the beat counter.
  assign wr_idx    = (state == IDLE) ? addr_idx : burst_idx;

  // rd_valid is included so waitrequest stays high while the last read beat
  // is on data_out and drops the cycle after it.
  assign fsm_busy = (state == RD_LAT) || (state == RD_BURST) || rd_valid;

`ifdef BURST_SRAM_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign stall = ((state == IDLE) || (state == WR_BURST)) && (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign waitrequest = fsm_busy | stall;

  // wr has priority over rd in IDLE; a losing rd stays pending at the host.
  assign wr_take = wr && !waitrequest && ((state == IDLE) || (state == WR_BURST));
  assign rd_take = rd && !wr && !waitrequest && (state == IDLE);

  // NOTE: the array has no reset; contents survive reset by design, and a
  // reset loop over every word would stop it mapping onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_take) begin
      mem[wr_idx] <= data_in;
    end
  end

  // NOTE: every register here is assigned with <= so all of them update
  // together from the values they held before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      len_q    <= '0;
      lat_cnt  <= '0;
      base_idx <= '0;
      rd_valid <= 1'b0;
      data_out <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_take) begin
            base_idx <= addr_idx;
            len_q    <= burst_len;
            if (burst_len != '0) begin
              beat_cnt <= BURSTLEN_WIDTH'(1);
              state    <= WR_BURST;
            end
          end else if (rd_take) begin
            base_idx <= addr_idx;
            len_q    <= burst_len;
            beat_cnt <= '0;
            lat_cnt  <= 3'd1;
            // With a one-cycle latency the first beat is fetched on the very
            // next edge, so the latency wait is skipped.
            state    <= (RD_LATENCY == 1) ? RD_BURST : RD_LAT;
          end
        end

        RD_LAT: begin
          if (lat_cnt == LAT_LAST) begin
            state <= RD_BURST;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end

        RD_BURST: begin
          rd_valid <= 1'b1;
          data_out <= mem[burst_idx];
          if (beat_cnt == len_q) begin
            beat_cnt <= '0;
            state    <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + BURSTLEN_WIDTH'(1);
          end
        end

        WR_BURST: begin
          // A cycle without an accepted beat is a bubble: nothing changes.
          if (wr_take) begin
            if (beat_cnt == len_q) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + BURSTLEN_WIDTH'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_burst_sram_slave
//
// Self-checking bench for burst_sram_slave with a 16-word array and a read
// latency of 2. Read data is checked by a scoreboard: expected beats are
// queued when a read is accepted and popped as rd_valid beats appear. A table
// of write/read-back vectors covers plain bursts, wrap and upper address bits;
// hand-written sequences cover reset mid-burst, write bubbles and the rd+wr
// collision. With BURST_SRAM_STALL_EN defined, a random-burst phase also
// compares waitrequest against a reference LFSR model.
// -----------------------------------------------------------------------------
module tb_burst_sram_slave;

  localparam int DL  = 4;
  localparam int LAT = 2;
  localparam int NW  = 1 << DL;

  logic        clock;
  logic        reset;
  logic [31:0] addr;
  logic [2:0]  burst_len;
  logic        rd;
  logic        wr;
  logic [31:0] data_in;
  logic        waitrequest;
  logic [31:0] data_out;
  logic        rd_valid;

  burst_sram_slave #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .BURSTLEN_WIDTH(3),
    .DEPTH_LOG2    (DL),
    .RD_LATENCY    (LAT),
    .MEM_FILE      ("")
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .addr       (addr),
    .burst_len  (burst_len),
    .rd         (rd),
    .wr         (wr),
    .data_in    (data_in),
    .waitrequest(waitrequest),
    .data_out   (data_out),
    .rd_valid   (rd_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] shadow [NW];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] base;      // beat i carries base*(i+1)
    logic [31:0] chk_addr;  // single word read back afterwards
    logic [31:0] chk_data;  // value that word must hold
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[DL+1:2]);
  endfunction

  // Read-data scoreboard.
  always @(negedge clock) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected_beat: got data %0h with nothing expected", data_out);
      end else begin
        check("rd_data", data_out, exp_q.pop_front());
      end
    end
  end

  // Write burst; pat gives wr per cycle (bit c), or random bubbles if rnd.
  task automatic do_write(input logic [31:0] a, input logic [2:0] len, input logic [31:0] base,
                          input logic [15:0] pat, input bit rnd, output int cycles);
    int   beat = 0;
    int   c    = 0;
    logic go;
    while (beat <= int'(len) && c < 200) begin
      @(posedge clock); #1;
      go        = rnd ? ($urandom_range(0, 3) != 0) : pat[c % 16];
      addr      = a;
      burst_len = len;
      rd        = 1'b0;
      wr        = go;
      data_in   = go ? base * (beat + 1) : (32'hDEAD_0000 | c);
      @(negedge clock);
      if (wr && !waitrequest) begin
        shadow[(widx(a) + beat) % NW] = data_in;
        beat++;
      end
      c++;
    end
    check("wr_beats", beat, int'(len) + 1);
    cycles = c;
  endtask

  // Read burst: queue expected beats at acceptance, then check latency,
  // beat count, contiguity and the waitrequest tail.
  task automatic do_read(input logic [31:0] a, input logic [2:0] len, input bit use_exp,
                         input logic [31:0] exp, output int waits);
    int   w   = 0;
    int   lat = 0;
    int   nb  = 0;
    logic wait_last = 1'b0;
    @(posedge clock); #1;
    addr      = a;
    burst_len = len;
    rd        = 1'b1;
    wr        = 1'b0;
    @(negedge clock);
    while (waitrequest && w < 64) begin
      @(negedge clock);
      w++;
    end
    check("rd_accept", waitrequest, 1'b0);
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back((use_exp && i == 0) ? exp : shadow[(widx(a) + i) % NW]);
    end
    @(posedge clock); #1;
    rd = 1'b0;
    @(negedge clock);
    while (!rd_valid && lat < 16) begin
      @(negedge clock);
      lat++;
    end
    check("rd_latency", lat, LAT);
    while (rd_valid && nb < 16) begin
      nb++;
      wait_last = waitrequest;
      @(negedge clock);
    end
    check("rd_beats", nb, int'(len) + 1);
    check("rd_wait_last_beat", wait_last, 1'b1);
`ifndef BURST_SRAM_STALL_EN
    check("rd_wait_drop", waitrequest, 1'b0);
`endif
    waits = w;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      rd = 1'b0;
      wr = 1'b0;
    end
  endtask

`ifdef BURST_SRAM_STALL_EN
  // Reference model of waitrequest under forced stalls.
  bit       model_en = 1'b0;
  logic [7:0] m_lfsr;
  bit       m_pred;
  bit       m_inwr;
  int       m_busy, m_wcnt, m_wlen;
  int       pred_cnt = 0;
  int       act_cnt  = 0;
  int       diff_cnt = 0;

  always @(negedge clock) begin
    if (model_en) begin
      m_pred = (m_busy != 0) || (m_lfsr[1:0] == 2'b00);
      if (m_pred) pred_cnt++;
      if (waitrequest) act_cnt++;
      if (m_pred != waitrequest) diff_cnt++;
    end
  end

  always @(posedge clock) begin
    if (model_en) begin
      if (m_busy != 0) begin
        m_busy--;
      end else if (!m_pred) begin
        if (wr) begin
          if (!m_inwr) begin
            if (burst_len != 3'd0) begin
              m_inwr = 1'b1;
              m_wcnt = 1;
              m_wlen = int'(burst_len);
            end
          end else if (m_wcnt == m_wlen) begin
            m_inwr = 1'b0;
          end else begin
            m_wcnt++;
          end
        end else if (rd && !m_inwr) begin
          m_busy = LAT + int'(burst_len) + 1;
        end
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w;
    int lat;

    vecs[0] = '{addr: 32'h0000_0100, len: 3'd3, base: 32'h11,   chk_addr: 32'h08, chk_data: 32'h33};
    vecs[1] = '{addr: 32'h0000_0038, len: 3'd3, base: 32'h300,  chk_addr: 32'h00, chk_data: 32'h900};
    vecs[2] = '{addr: 32'hFFFF_0104, len: 3'd0, base: 32'h5A,   chk_addr: 32'h04, chk_data: 32'h5A};
    vecs[3] = '{addr: 32'h0000_002C, len: 3'd7, base: 32'h7,    chk_addr: 32'h08, chk_data: 32'h38};
    vecs[4] = '{addr: 32'h0000_003F, len: 3'd1, base: 32'h1000, chk_addr: 32'h00, chk_data: 32'h2000};

    reset = 1'b1; rd = 1'b0; wr = 1'b0;
    addr = '0; burst_len = '0; data_in = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_waitrequest", waitrequest, 1'b0);
    check("reset_data_out", data_out, 32'h0);

    // Fill every word so later reads have a known value.
    for (int k = 0; k < NW / 4; k++) begin
      do_write(32'(k * 16), 3'd3, 32'hA0 + 32'(k), 16'hFFFF, 1'b0, cyc);
    end

    // Reset while three read beats are still pending.
    @(posedge clock); #1;
    addr = 32'h0; burst_len = 3'd3; rd = 1'b1; wr = 1'b0;
    @(negedge clock);
    w = 0;
    while (waitrequest && w < 64) begin
      @(negedge clock);
      w++;
    end
    check("t1_accept", waitrequest, 1'b0);
    exp_q.push_back(shadow[0]);
    @(posedge clock); #1;
    rd = 1'b0;
    @(negedge clock);
    lat = 0;
    while (!rd_valid && lat < 16) begin
      @(negedge clock);
      lat++;
    end
    check("t1_first_beat", rd_valid, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("t1_rd_valid", rd_valid, 1'b0);
    check("t1_waitrequest", waitrequest, 1'b0);
    check("t1_data_out", data_out, 32'h0);
    idle(6);
    check("t1_queue_empty", exp_q.size(), 0);
    do_read(32'h0, 3'd3, 1'b0, 32'h0, w);

    // Write / read-back table: plain burst, wrap, upper address bits.
    foreach (vecs[i]) begin
      do_write(vecs[i].addr, vecs[i].len, vecs[i].base, 16'hFFFF, 1'b0, cyc);
      do_read(vecs[i].addr, vecs[i].len, 1'b0, 32'h0, w);
      do_read(vecs[i].chk_addr, 3'd0, 1'b1, vecs[i].chk_data, w);
    end

    // Write bubbles 1,0,0,1,1,0,1 for four beats at word 4; word 8 must be untouched.
    do_write(32'h10, 3'd3, 32'h40, 16'h0059, 1'b0, cyc);
`ifndef BURST_SRAM_STALL_EN
    check("t4_cycles", cyc, 7);
`endif
    do_read(32'h10, 3'd4, 1'b0, 32'h0, w);
`ifndef BURST_SRAM_STALL_EN
    check("t4_idle_after", w, 0);
`endif

    // rd and wr together in IDLE: the write goes first, rd stays high.
    @(posedge clock); #1;
    addr = 32'h24; burst_len = 3'd0; rd = 1'b1; wr = 1'b1; data_in = 32'h00C0_FFEE;
    @(negedge clock);
    w = 0;
    while (waitrequest && w < 64) begin
      @(negedge clock);
      w++;
    end
    check("t5_wr_accept", waitrequest, 1'b0);
    shadow[widx(32'h24)] = 32'h00C0_FFEE;
    do_read(32'h24, 3'd0, 1'b1, 32'h00C0_FFEE, w);
`ifndef BURST_SRAM_STALL_EN
    check("t5_rd_follows", w, 0);
`endif

`ifdef BURST_SRAM_STALL_EN
    @(posedge clock); #1;
    reset = 1'b1; rd = 1'b0; wr = 1'b0;
    @(posedge clock); #1;
    reset    = 1'b0;
    m_lfsr   = 8'hA5;
    m_busy   = 0;
    m_inwr   = 1'b0;
    m_wcnt   = 0;
    m_wlen   = 0;
    model_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write($urandom, 3'($urandom_range(0, 7)), $urandom, 16'hFFFF, 1'b1, cyc);
      end else begin
        do_read($urandom, 3'($urandom_range(0, 7)), 1'b0, 32'h0, w);
      end
    end
    idle(2);
    model_en = 1'b0;
    check("t6_wait_count", act_cnt, pred_cnt);
    check("t6_wait_cycle_diff", diff_cnt, 0);
`endif

    idle(4);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
